// File: rtl/timer_bus_arbiter.sv
`default_nettype none
// ============================================================================
// timer_bus_arbiter: round-robin two-master arbiter for the timer register bus
// Rev 1.0
// ============================================================================
module timer_bus_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic              i_m0_select,
  input  logic              i_m0_wr,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_data,
  output logic [DATA_W-1:0] o_m0_data,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic              i_m1_select,
  input  logic              i_m1_wr,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_data,
  output logic [DATA_W-1:0] o_m1_data,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic              o_bus_select,
  output logic              o_bus_wr,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_ack,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  state_t                   state, state_next;
  logic                     last_grant, last_grant_next;
  logic                     owner, owner_next;
  logic [TO_W-1:0]          cnt, cnt_next;
  logic                     bus_select, bus_select_next;
  logic                     bus_wr, bus_wr_next;
  logic [ADDR_W-1:0]        reg_addr, reg_addr_next;
  logic [DATA_W-1:0]        bus_data, bus_data_next;
  logic [1:0]               grant, grant_next;
  logic [1:0]               ack, ack_next;
  logic [1:0]               err, err_next;
  logic [1:0][DATA_W-1:0]   rdata, rdata_next;

  logic [1:0]               req;
  logic [1:0]               req_wr;
  logic [1:0][ADDR_W-1:0]   req_addr;
  logic [1:0][DATA_W-1:0]   req_data;
  logic                     pick;
  logic                     pick_valid;

  assign req      = {i_m1_select, i_m0_select};
  assign req_wr   = {i_m1_wr, i_m0_wr};
  assign req_addr = {i_m1_addr, i_m0_addr};
  assign req_data = {i_m1_data, i_m0_data};

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    owner_next      = owner;
    cnt_next        = cnt;
    bus_select_next = bus_select;
    bus_wr_next     = bus_wr;
    reg_addr_next   = reg_addr;
    bus_data_next   = bus_data;
    grant_next      = grant;
    ack_next        = ack;
    err_next        = err;
    rdata_next      = rdata;
    pick            = 1'b0;
    pick_valid      = 1'b0;

    case (state)
      ST_IDLE: begin
        // On a tie the master that was not served last wins.
        if (req[0] && (!req[1] || last_grant)) begin
          pick_valid = 1'b1;
          pick       = 1'b0;
        end else if (req[1]) begin
          pick_valid = 1'b1;
          pick       = 1'b1;
        end
        if (pick_valid) begin
          state_next      = ST_BUSY;
          owner_next      = pick;
          last_grant_next = pick;
          cnt_next        = '0;
          bus_select_next = 1'b1;
          bus_wr_next     = req_wr[pick];
          reg_addr_next   = req_addr[pick];
          bus_data_next   = req_data[pick];
          grant_next      = pick ? 2'b10 : 2'b01;
        end
      end

      ST_BUSY: begin
        cnt_next = cnt + 1'b1;
        // A slave ack arriving on the timeout edge still counts as success.
        if (i_bus_ack || (cnt == CNT_LAST)) begin
          state_next        = ST_RELEASE;
          bus_select_next   = 1'b0;
          ack_next[owner]   = 1'b1;
          err_next[owner]   = ~i_bus_ack;
          rdata_next[owner] = (i_bus_ack && !bus_wr) ? i_bus_data : '0;
        end
      end

      ST_RELEASE: begin
        if (!req[owner] && !i_bus_ack) begin
          state_next = ST_IDLE;
          ack_next   = '0;
          err_next   = '0;
          rdata_next = '0;
          grant_next = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
      bus_select <= 1'b0;
      bus_wr     <= 1'b0;
      reg_addr   <= '0;
      bus_data   <= '0;
      grant      <= '0;
      ack        <= '0;
      err        <= '0;
      rdata      <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      owner      <= owner_next;
      cnt        <= cnt_next;
      bus_select <= bus_select_next;
      bus_wr     <= bus_wr_next;
      reg_addr   <= reg_addr_next;
      bus_data   <= bus_data_next;
      grant      <= grant_next;
      ack        <= ack_next;
      err        <= err_next;
      rdata      <= rdata_next;
    end
  end

  assign o_bus_select = bus_select;
  assign o_bus_wr     = bus_wr;
  assign o_reg_addr   = reg_addr;
  assign o_bus_data   = bus_data;
  assign o_grant      = grant;
  assign o_busy       = (state != ST_IDLE);
  assign o_m0_ack     = ack[0];
  assign o_m0_err     = err[0];
  assign o_m0_data    = rdata[0];
  assign o_m1_ack     = ack[1];
  assign o_m1_err     = err[1];
  assign o_m1_data    = rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_timer_bus_arbiter.sv
`default_nettype none
// tb_timer_bus_arbiter: randomized two-master traffic against a transaction-level scoreboard.
module tb_timer_bus_arbiter;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]          sel, wr;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  wdata;
  logic [1:0][DW-1:0]  rdata;
  logic [1:0]          ack, err;
  logic                bus_select, bus_wr, bus_ack, busy;
  logic [AW-1:0]       reg_addr;
  logic [DW-1:0]       bus_wdata, bus_rdata;
  logic [1:0]          grant;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t expq0[$];
  txn_t expq1[$];
  int   checks = 0;
  int   errors = 0;
  int   last_served = 1;
  int   cyc = 0;

  timer_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TO_W(8)) dut (
    .i_sysclk(clk), .i_sysrst(rst),
    .i_m0_select(sel[0]), .i_m0_wr(wr[0]), .i_m0_addr(addr[0]), .i_m0_data(wdata[0]),
    .o_m0_data(rdata[0]), .o_m0_ack(ack[0]), .o_m0_err(err[0]),
    .i_m1_select(sel[1]), .i_m1_wr(wr[1]), .i_m1_addr(addr[1]), .i_m1_data(wdata[1]),
    .o_m1_data(rdata[1]), .o_m1_ack(ack[1]), .o_m1_err(err[1]),
    .o_bus_select(bus_select), .o_bus_wr(bus_wr), .o_reg_addr(reg_addr),
    .o_bus_data(bus_wdata), .i_bus_data(bus_rdata), .i_bus_ack(bus_ack),
    .o_grant(grant), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // The slave returns a fixed word per register; address F never acknowledges.
  function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a);
    return 16'hC3A5 ^ {4{a}};
  endfunction

  function automatic void qpush(input int n, input txn_t t);
    if (n == 0) expq0.push_back(t); else expq1.push_back(t);
  endfunction
  function automatic int qsize(input int n);
    return (n == 0) ? expq0.size() : expq1.size();
  endfunction
  function automatic txn_t qfront(input int n);
    return (n == 0) ? expq0[0] : expq1[0];
  endfunction
  function automatic txn_t qpop(input int n);
    txn_t t;
    if (n == 0) t = expq0.pop_front(); else t = expq1.pop_front();
    return t;
  endfunction

  // Slave model
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_select && !rst && reg_addr != 4'hF) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = slave_word(reg_addr);
        repeat ($urandom_range(1, 3)) @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = DW'($urandom);
      end
    end
  end

  // Monitor: grant order, slave-side fields and per-master completions
  initial begin
    logic       prev_sel;
    logic [1:0] prev_ack;
    logic [1:0] exp_grant;
    int         exp_own, start;
    bit         exp_err;
    txn_t       cur;
    prev_sel = 1'b0;
    prev_ack = 2'b00;
    start    = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_sel    = 1'b0;
        prev_ack    = 2'b00;
        last_served = 1;
        expq0.delete();
        expq1.delete();
        continue;
      end
      if (ack != 2'b00) check("ack_matches_grant", 32'(ack), 32'(grant));
      if (bus_select && !prev_sel) begin
        exp_own   = (sel == 2'b11) ? 1 - last_served : (sel[1] ? 1 : 0);
        exp_grant = (sel == 2'b00) ? 2'b00 : 2'(1 << exp_own);
        check("grant", 32'(grant), 32'(exp_grant));
        check("busy_on_grant", 32'(busy), 32'd1);
        last_served = exp_own;
        check("grant_pending", 32'(qsize(exp_own) != 0), 32'd1);
        if (qsize(exp_own) != 0) begin
          cur = qfront(exp_own);
          check("bus_wr", 32'(bus_wr), 32'(cur.wr));
          check("reg_addr", 32'(reg_addr), 32'(cur.addr));
          check("bus_data", 32'(bus_wdata), 32'(cur.data));
        end
        start = cyc;
      end
      for (int n = 0; n < 2; n++) begin
        if (ack[n] && !prev_ack[n]) begin
          check("ack_expected", 32'(qsize(n) != 0), 32'd1);
          if (qsize(n) != 0) begin
            cur     = qpop(n);
            exp_err = (cur.addr == 4'hF);
            check("err", 32'(err[n]), 32'(exp_err));
            check("rdata", 32'(rdata[n]), 32'((exp_err || cur.wr) ? 16'h0 : slave_word(cur.addr)));
            check("select_dropped", 32'(bus_select), 32'd0);
            check("hold_wr", 32'(bus_wr), 32'(cur.wr));
            check("hold_addr", 32'(reg_addr), 32'(cur.addr));
            check("hold_data", 32'(bus_wdata), 32'(cur.data));
            if (exp_err) check("timeout_cycles", 32'(cyc - start), 32'(TMO));
          end
        end
        if (!ack[n] && prev_ack[n]) check("ack_fall_cond", 32'({sel[n], bus_ack}), 32'd0);
        if (!ack[n]) check("idle_outputs", 32'({err[n], rdata[n]}), 32'd0);
      end
      prev_sel = bus_select;
      prev_ack = ack;
    end
  end

  task automatic run_master(input int n, input int count, input bit first_now);
    txn_t t;
    int   k;
    bit   drop;
    for (int i = 0; i < count; i++) begin
      if (!(first_now && i == 0)) repeat ($urandom_range(0, 4)) @(negedge clk);
      t.wr   = 1'($urandom_range(0, 1));
      t.addr = AW'($urandom_range(0, 15));
      t.data = DW'($urandom);
      if (n == 1 && i == 2) t.addr = 4'hF;
      wr[n] = t.wr; addr[n] = t.addr; wdata[n] = t.data; sel[n] = 1'b1;
      qpush(n, t);
      drop = ($urandom_range(0, 5) == 0);
      k = 0;
      while (!ack[n] && k < 400) begin
        @(negedge clk);
        k++;
        if (grant[n] && !ack[n]) begin
          wr[n]    = 1'($urandom);
          addr[n]  = AW'($urandom);
          wdata[n] = DW'($urandom);
          if (drop) sel[n] = 1'b0;
        end
      end
      if (!ack[n]) check("ack_wait", 32'(ack[n]), 32'd1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sel[n] = 1'b0;
      k = 0;
      while (ack[n] && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (ack[n]) check("ack_release", 32'(ack[n]), 32'd0);
    end
  endtask

  initial begin
    int k;
    sel = '0; wr = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check("reset_outputs", 32'({bus_select, bus_wr, reg_addr, bus_wdata, grant, busy, ack, err}), 32'd0);
    check("reset_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    fork
      run_master(0, 30, 1'b1);
      run_master(1, 30, 1'b1);
    join
    repeat (5) @(negedge clk);

    // Abort a transaction in flight with reset
    wr[0] = 1'b1; addr[0] = 4'hF; wdata[0] = 16'h1234; sel[0] = 1'b1;
    qpush(0, '{wr: 1'b1, addr: 4'hF, data: 16'h1234});
    k = 0;
    while (!busy && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("abort_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_outputs", 32'({bus_select, grant, busy, ack, err}), 32'd0);
    check("abort_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sel[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("no_ack_after_abort", 32'(ack), 32'd0);

    // Tie after reset goes to m0; a tie after m0 alone goes to m1
    fork
      run_master(0, 1, 1'b1);
      run_master(1, 1, 1'b1);
    join
    run_master(0, 1, 1'b1);
    fork
      run_master(0, 1, 1'b1);
      run_master(1, 1, 1'b1);
    join
    repeat (5) @(negedge clk);
    check("queues_drained", 32'(qsize(0) + qsize(1)), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
